// File: rtl/rotor_ftob_pipe.sv
// -----------------------------------------------------------------------------
// rotor_ftob_pipe
//
// Forward (front-to-back) rotor path of the 64-symbol Enigma core.
// This block owns the rotor stepping odometer. Every accepted symbol steps the
// odometer first. The symbol then passes through rotor 0, rotor 1 and rotor 2
// in a three-stage valid/ready pipeline. Each result carries the rotor
// positions it was enciphered with, so the back-to-front path can reuse them.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   load              load load_r0/1/2 into the odometer (blocks input)
//   load_r0..load_r2  initial rotor positions
//   in_valid/in_ready input handshake for data_in
//   data_in           plaintext symbol (post-plugboard)
//   out_valid/out_ready output handshake for data_out
//   data_out          symbol after rotor 2
//   r0/r1/r2_position rotor positions used for data_out, held with it
// -----------------------------------------------------------------------------
module rotor_ftob_pipe #(
    parameter int SYM_W  = 6,
    parameter int A0     = 5,
    parameter int B0     = 17,
    parameter int A1     = 11,
    parameter int B1     = 3,
    parameter int A2     = 29,
    parameter int B2     = 41,
    parameter int NOTCH0 = 16,
    parameter int NOTCH1 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SYM_W-1:0] load_r0,
    input  logic [SYM_W-1:0] load_r1,
    input  logic [SYM_W-1:0] load_r2,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] data_out,
    output logic [SYM_W-1:0] r0_position,
    output logic [SYM_W-1:0] r1_position,
    output logic [SYM_W-1:0] r2_position
);

    localparam int PW = 2 * SYM_W;

    // Rotor at position p: shift the input by p, apply the affine wiring
    // (a*x + b), then shift back by p. All arithmetic wraps at 2**SYM_W,
    // which the fixed-width truncation gives us for free.
    function automatic logic [SYM_W-1:0] rotor_map(
        input logic [SYM_W-1:0] x,
        input logic [SYM_W-1:0] p,
        input int               a,
        input int               b
    );
        logic [SYM_W-1:0] shifted;
        logic [PW-1:0]    prod;
        logic [SYM_W-1:0] wired;
        shifted = x + p;
        prod    = {{SYM_W{1'b0}}, shifted} * PW'(a);
        wired   = prod[SYM_W-1:0] + SYM_W'(b);
        return wired - p;
    endfunction

    // Odometer (current positions) and its stepped value
    logic [SYM_W-1:0] pos0, pos1, pos2;
    logic [SYM_W-1:0] next0, next1, next2;
    logic             carry1, carry2;

    // Pipeline stage registers
    logic             s1_valid, s2_valid, s3_valid;
    logic [SYM_W-1:0] s1_data, s2_data, s3_data;
    logic [SYM_W-1:0] s1_p0, s1_p1, s1_p2;
    logic [SYM_W-1:0] s2_p0, s2_p1, s2_p2;
    logic [SYM_W-1:0] s3_p0, s3_p1, s3_p2;

    logic adv;
    logic accept;

    // The whole pipeline moves as one; it only freezes when the output
    // holds a symbol that downstream is not taking.
    assign adv      = out_ready | ~s3_valid;
    assign in_ready = adv & ~load;
    assign accept   = in_valid & in_ready;

    // Stepping is decided from the positions before the step: rotor 1 moves
    // when rotor 0 leaves its notch, rotor 2 only when rotor 1 actually moves
    // and leaves its own notch. A plain wrap of rotor 0 is not a carry.
    always_comb begin
        carry1 = (pos0 == SYM_W'(NOTCH0));
        carry2 = carry1 & (pos1 == SYM_W'(NOTCH1));
        next0  = pos0 + SYM_W'(1);
        next1  = carry1 ? pos1 + SYM_W'(1) : pos1;
        next2  = carry2 ? pos2 + SYM_W'(1) : pos2;
    end

    // Odometer register: a load overrides everything; otherwise it steps once
    // per accepted symbol. load and accept never coincide since load blocks
    // in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos0 <= '0;
            pos1 <= '0;
            pos2 <= '0;
        end else if (load) begin
            pos0 <= load_r0;
            pos1 <= load_r1;
            pos2 <= load_r2;
        end else if (accept) begin
            pos0 <= next0;
            pos1 <= next1;
            pos2 <= next2;
        end
    end

    // Three pipeline stages. Stage 1 enciphers with the freshly stepped
    // rotor 0 position and snapshots all three stepped positions; later
    // stages use the positions carried alongside their symbol, so a load
    // never disturbs symbols already in flight. Empty slots shift through
    // with valid = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_p0    <= '0;
            s1_p1    <= '0;
            s1_p2    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_p0    <= '0;
            s2_p1    <= '0;
            s2_p2    <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_p0    <= '0;
            s3_p1    <= '0;
            s3_p2    <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_data  <= rotor_map(data_in, next0, A0, B0);
            s1_p0    <= next0;
            s1_p1    <= next1;
            s1_p2    <= next2;

            s2_valid <= s1_valid;
            s2_data  <= rotor_map(s1_data, s1_p1, A1, B1);
            s2_p0    <= s1_p0;
            s2_p1    <= s1_p1;
            s2_p2    <= s1_p2;

            s3_valid <= s2_valid;
            s3_data  <= rotor_map(s2_data, s2_p2, A2, B2);
            s3_p0    <= s2_p0;
            s3_p1    <= s2_p1;
            s3_p2    <= s2_p2;
        end
    end

    assign out_valid   = s3_valid;
    assign data_out    = s3_data;
    assign r0_position = s3_p0;
    assign r1_position = s3_p1;
    assign r2_position = s3_p2;

endmodule

// File: tb/tb_rotor_ftob_pipe.sv
// -----------------------------------------------------------------------------
// tb_rotor_ftob_pipe
//
// Self-checking bench for rotor_ftob_pipe. Directed vectors cover the odometer
// corner cases, hand-written sequences cover load/accept collision and
// mid-flight reset, and a randomized stream is scored against a plain
// arithmetic reference model with a queue of expected results.
// -----------------------------------------------------------------------------
module tb_rotor_ftob_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_r0 = '0;
    logic [5:0] load_r1 = '0;
    logic [5:0] load_r2 = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] data_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] data_out;
    logic [5:0] r0_position;
    logic [5:0] r1_position;
    logic [5:0] r2_position;

    int total = 0;
    int bad   = 0;

    rotor_ftob_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_r0    (load_r0),
        .load_r1    (load_r1),
        .load_r2    (load_r2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .r0_position(r0_position),
        .r1_position(r1_position),
        .r2_position(r2_position)
    );

    always #5 clk = ~clk;

    // Reference model: rotors as modular arithmetic on plain integers
    function automatic int rot(input int x, input int p, input int a, input int b);
        int t;
        t = (x + p) % 64;
        return ((a * t + b) % 64 - p + 64) % 64;
    endfunction

    function automatic int ref_path(input int x, input int q0, input int q1, input int q2);
        return rot(rot(rot(x, q0, 5, 17), q1, 11, 3), q2, 29, 41);
    endfunction

    // Model odometer and scoreboard
    int m0, m1, m2;
    logic [23:0] exp_q[$];
    int accepted_cnt, popped_cnt;

    task automatic model_step();
        bit c1, c2;
        c1 = (m0 == 16);
        c2 = c1 && (m1 == 4);
        m0 = (m0 + 1) % 64;
        if (c1) m1 = (m1 + 1) % 64;
        if (c2) m2 = (m2 + 1) % 64;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit lv, input int l0, input int l1, input int l2,
                                 input bit iv, input int sym, input bit ordy);
        load      = lv;
        load_r0   = l0[5:0];
        load_r1   = l1[5:0];
        load_r2   = l2[5:0];
        in_valid  = iv;
        data_in   = sym[5:0];
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Present one symbol, then wait (bounded) for it to come out
    task automatic sendAndWait(input int sym, output int cycles);
        applyStimulus(0, 0, 0, 0, 1, sym, 1);
        checkOutput("send_in_ready", int'(in_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        cycles = 1;
        while (!out_valid && cycles < 12) begin
            tick();
            cycles++;
        end
    endtask

    // One streaming cycle scored against the model
    task automatic streamCycle(input bit lv, input int l0, input int l1, input int l2,
                               input bit iv, input int sym, input bit ordy);
        bit          acc, hold;
        int          exp_rdy;
        logic [23:0] held, got, expv;
        applyStimulus(lv, l0, l1, l2, iv, sym, ordy);
        exp_rdy = (!lv && (ordy || !out_valid)) ? 1 : 0;
        checkOutput("in_ready_rule", int'(in_ready), exp_rdy);
        acc  = iv && in_ready;
        hold = out_valid && !ordy;
        held = {data_out, r0_position, r1_position, r2_position};
        if (out_valid && ordy) begin
            got = {data_out, r0_position, r1_position, r2_position};
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", int'(got), -1);
            end else begin
                expv = exp_q.pop_front();
                checkOutput("stream_result", int'(got), int'(expv));
            end
            popped_cnt++;
        end
        @(posedge clk);
        if (lv) begin
            m0 = l0; m1 = l1; m2 = l2;
        end
        if (acc) begin
            model_step();
            exp_q.push_back({6'(ref_path(sym, m0, m1, m2)), 6'(m0), 6'(m1), 6'(m2)});
            accepted_cnt++;
        end
        #1;
        if (hold) begin
            checkOutput("stall_valid_hold", int'(out_valid), 1);
            checkOutput("stall_data_hold",
                        int'({data_out, r0_position, r1_position, r2_position}), int'(held));
        end
    endtask

    typedef struct {
        bit do_load;
        int l0, l1, l2;
        int sym;
        int exp_data;
        int e0, e1, e2;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int n;

        // Directed vectors: odometer carries, wrap, first-symbol value
        vecs[0] = '{1, 0,  0, 0,  6,  13,                       1,  0, 0};
        vecs[1] = '{1, 16, 4, 7,  0,  ref_path(0, 17, 5, 8),    17, 5, 8};
        vecs[2] = '{0, 0,  0, 0,  1,  ref_path(1, 18, 5, 8),    18, 5, 8};
        vecs[3] = '{1, 63, 0, 0,  9,  ref_path(9, 0, 0, 0),     0,  0, 0};
        vecs[4] = '{0, 0,  0, 0,  63, ref_path(63, 1, 0, 0),    1,  0, 0};
        vecs[5] = '{1, 3,  4, 5,  20, ref_path(20, 4, 4, 5),    4,  4, 5};
        vecs[6] = '{1, 16, 3, 63, 5,  ref_path(5, 17, 4, 63),   17, 4, 63};
        vecs[7] = '{1, 16, 4, 63, 2,  ref_path(2, 17, 5, 0),    17, 5, 0};

        // Reset state
        rst_n = 1'b0;
        #3;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_positions", int'({r0_position, r1_position, r2_position}), 0);
        doReset();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_load) begin
                applyStimulus(1, vecs[i].l0, vecs[i].l1, vecs[i].l2, 0, 0, 1);
                checkOutput("load_blocks_ready", int'(in_ready), 0);
                tick();
            end
            sendAndWait(vecs[i].sym, cyc);
            checkOutput($sformatf("vec%0d_latency", i), cyc, 3);
            checkOutput($sformatf("vec%0d_data", i), int'(data_out), vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_r0", i), int'(r0_position), vecs[i].e0);
            checkOutput($sformatf("vec%0d_r1", i), int'(r1_position), vecs[i].e1);
            checkOutput($sformatf("vec%0d_r2", i), int'(r2_position), vecs[i].e2);
            tick();
        end

        // Load coincident with in_valid: symbol waits one cycle, uses loaded+1
        applyStimulus(1, 20, 30, 40, 1, 7, 1);
        checkOutput("load_collision_ready", int'(in_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 7, 1);
        checkOutput("post_load_ready", int'(in_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            tick();
            cyc++;
        end
        checkOutput("collision_latency", cyc, 3);
        checkOutput("collision_data", int'(data_out), ref_path(7, 21, 30, 40));
        checkOutput("collision_positions",
                    int'({r0_position, r1_position, r2_position}),
                    int'({6'd21, 6'd30, 6'd40}));
        tick();

        // Mid-flight reset discards everything at once
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 10 + k, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_reset_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", int'(out_valid), 0);
        checkOutput("async_reset_data", int'(data_out), 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid) n++;
        end
        checkOutput("no_stale_output", n, 0);
        sendAndWait(6, cyc);
        checkOutput("after_reset_latency", cyc, 3);
        checkOutput("after_reset_data", int'(data_out), 13);
        checkOutput("after_reset_positions",
                    int'({r0_position, r1_position, r2_position}),
                    int'({6'd1, 6'd0, 6'd0}));

        // Streaming against the model: 8 symbols with a 3-cycle stall
        doReset();
        m0 = 0; m1 = 0; m2 = 0;
        exp_q.delete();
        accepted_cnt = 0;
        popped_cnt = 0;
        n = 0;
        while (accepted_cnt < 8 && n < 40) begin
            streamCycle(0, 0, 0, 0, 1, int'($urandom_range(0, 63)), !(n >= 4 && n < 7));
            n++;
        end
        checkOutput("stream8_accepted", accepted_cnt, 8);

        // Randomized traffic with occasional loads near the notches
        for (int c = 0; c < 400; c++) begin
            bit lv;
            int l0, l1;
            lv = ($urandom_range(0, 15) == 0);
            l0 = ($urandom_range(0, 1) != 0) ? 16 : int'($urandom_range(0, 63));
            l1 = ($urandom_range(0, 1) != 0) ? 4 : int'($urandom_range(0, 63));
            streamCycle(lv, l0, l1, int'($urandom_range(0, 63)),
                        ($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
                        ($urandom_range(0, 3) != 0));
        end

        // Drain
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            streamCycle(0, 0, 0, 0, 0, 0, 1);
            n++;
        end
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        checkOutput("none_lost_or_duplicated", popped_cnt, accepted_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
